// File: rtl/nco_pkg.sv
// Shared types and default widths for the LUT-based NCO controller.
`default_nettype none

package nco_pkg;

   localparam int NCO_DATA_WIDTH = 16;
   localparam int NCO_ADDR_WIDTH = 8;
   localparam int NCO_ACC_WIDTH  = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } nco_state_e;

   // Upper ADDR_WIDTH bits of the phase word select the table entry.
   function automatic logic [NCO_ADDR_WIDTH-1:0] phase_to_addr(
      input logic [NCO_ACC_WIDTH-1:0] phase
   );
      return phase[NCO_ACC_WIDTH-1 -: NCO_ADDR_WIDTH];
   endfunction

endpackage

`default_nettype wire

// File: rtl/nco_phase_acc.sv
// Phase accumulator driving the SRAM read port, plus the two-stage
// valid/capture pipeline that aligns the returned table word.
`default_nettype none

module nco_phase_acc
   import nco_pkg::*;
#(
   parameter int DATA_WIDTH = NCO_DATA_WIDTH,
   parameter int ADDR_WIDTH = NCO_ADDR_WIDTH,
   parameter int ACC_WIDTH  = NCO_ACC_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue,
   input  logic [ACC_WIDTH-1:0]  fcw,
   output logic                  ram_csb1,
   output logic [ADDR_WIDTH-1:0] ram_addr1,
   input  logic [DATA_WIDTH-1:0] ram_dout1,
   output logic [DATA_WIDTH-1:0] sample,
   output logic                  sample_valid
);

   logic [ACC_WIDTH-1:0] phase;
   logic                 rd_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase        <= '0;
         ram_csb1     <= 1'b1;
         ram_addr1    <= '0;
         rd_pend      <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
      end else begin
         ram_csb1 <= ~issue;
         if (issue) begin
            ram_addr1 <= phase[ACC_WIDTH-1 -: ADDR_WIDTH];
            phase     <= phase + fcw;
         end
         // The SRAM latches the request one edge later and drives dout on
         // that cycle's negedge, so the word is ready two edges after issue.
         rd_pend      <= ~ram_csb1;
         sample_valid <= rd_pend;
         if (rd_pend) begin
            sample <= ram_dout1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ram_256x16.sv
// 256x16 two-port SRAM model: one write port, one read port; inputs are
// registered on posedge and the array is accessed on the following negedge.
`default_nettype none

module ram_256x16 (
   input  logic        clk0,
   input  logic        csb0,
   input  logic [7:0]  addr0,
   input  logic [15:0] din0,
   input  logic        clk1,
   input  logic        csb1,
   input  logic [7:0]  addr1,
   output logic [15:0] dout1
);

   logic [15:0] mem [256];

   logic        csb0_q;
   logic [7:0]  addr0_q;
   logic [15:0] din0_q;
   logic        csb1_q;
   logic [7:0]  addr1_q;

   always_ff @(posedge clk0) begin
      csb0_q  <= csb0;
      addr0_q <= addr0;
      din0_q  <= din0;
   end

   always_ff @(negedge clk0) begin
      if (!csb0_q) begin
         mem[addr0_q] <= din0_q;
      end
   end

   always_ff @(posedge clk1) begin
      csb1_q  <= csb1;
      addr1_q <= addr1;
   end

   always_ff @(negedge clk1) begin
      if (!csb1_q) begin
         dout1 <= mem[addr1_q];
      end
   end

endmodule

`default_nettype wire

// File: rtl/nco_lut_ctrl.sv
// NCO controller: loads a waveform table into an external SRAM, then sweeps
// it with a phase accumulator to produce a sample stream.
`default_nettype none

module nco_lut_ctrl
   import nco_pkg::*;
#(
   parameter int DATA_WIDTH = NCO_DATA_WIDTH,
   parameter int ADDR_WIDTH = NCO_ADDR_WIDTH,
   parameter int ACC_WIDTH  = NCO_ACC_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  run_en,
   input  logic [ACC_WIDTH-1:0]  fcw,
   output logic [DATA_WIDTH-1:0] sample,
   output logic                  sample_valid,
   output logic                  table_loaded,
   output logic                  busy,
   output logic                  ram_csb0,
   output logic [ADDR_WIDTH-1:0] ram_addr0,
   output logic [DATA_WIDTH-1:0] ram_din0,
   output logic                  ram_csb1,
   output logic [ADDR_WIDTH-1:0] ram_addr1,
   input  logic [DATA_WIDTH-1:0] ram_dout1
);

   nco_state_e            state;
   nco_state_e            state_nxt;
   logic [ADDR_WIDTH-1:0] wr_cnt;
   logic                  handshake;
   logic                  last_word;
   logic                  issue;
   logic                  load_req;

   assign last_word = &wr_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      busy      = 1'b1;
      handshake = 1'b0;
      issue     = 1'b0;
      load_req  = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (load_start) begin
               load_req  = 1'b1;
               state_nxt = ST_LOAD;
            end else if (run_en && table_loaded) begin
               state_nxt = ST_RUN;
            end
         end
         ST_LOAD: begin
            ld_ready  = 1'b1;
            handshake = ld_valid;
            if (ld_valid && last_word) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (run_en) begin
               issue = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Write port: one SRAM write per accepted table word.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt       <= '0;
         table_loaded <= 1'b0;
         ram_csb0     <= 1'b1;
         ram_addr0    <= '0;
         ram_din0     <= '0;
      end else begin
         ram_csb0 <= ~handshake;
         if (handshake) begin
            ram_addr0 <= wr_cnt;
            ram_din0  <= ld_data;
            wr_cnt    <= wr_cnt + 1'b1;
            if (last_word) begin
               table_loaded <= 1'b1;
            end
         end
         if (load_req) begin
            wr_cnt       <= '0;
            table_loaded <= 1'b0;
         end
      end
   end

   nco_phase_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_phase_acc (
      .clk          (clk),
      .rst          (rst),
      .issue        (issue),
      .fcw          (fcw),
      .ram_csb1     (ram_csb1),
      .ram_addr1    (ram_addr1),
      .ram_dout1    (ram_dout1),
      .sample       (sample),
      .sample_valid (sample_valid)
   );

endmodule

`default_nettype wire

// File: doc/nco_lut_ctrl.md
NCO_LUT_CTRL -- requirements
Module: nco_lut_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, LUT word width; ADDR_WIDTH, default 8, LUT address width; ACC_WIDTH, default 24, phase accumulator width.
REQ-002 SHALL have ports `clk`, input, 1 bit, the single clock; the 256x16 SRAM's clk0 and clk1 are tied to it externally.
REQ-003 SHALL have port `rst`, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port `load_start`, input, 1 bit, a pulse that begins a table load.
REQ-005 SHALL have ports `ld_valid`, input, 1 bit, and `ld_ready`, output, 1 bit, forming the table-word load handshake.
REQ-006 SHALL have port `ld_data`, input, DATA_WIDTH bits, the table word.
REQ-007 SHALL have port `run_en`, input, 1 bit, a level that enables synthesis.
REQ-008 SHALL have port `fcw`, input, ACC_WIDTH bits, the frequency control word, sampled every RUN cycle.
REQ-009 SHALL have ports `sample`, output, DATA_WIDTH bits, the LUT output, and `sample_valid`, output, 1 bit, its strobe.
REQ-010 SHALL have ports `table_loaded`, output, 1 bit, set after a complete load, and `busy`, output, 1 bit, high when not IDLE.
REQ-011 SHALL have SRAM write-port outputs: `ram_csb0`, 1 bit, active-low; `ram_addr0`, ADDR_WIDTH bits; `ram_din0`, DATA_WIDTH bits.
REQ-012 SHALL have SRAM read-port signals: `ram_csb1`, output, 1 bit, active-low; `ram_addr1`, output, ADDR_WIDTH bits; `ram_dout1`, input, DATA_WIDTH bits.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD and RUN.
REQ-014 SHALL make every RAM-side output a flop, since the SRAM registers its inputs on posedge and acts on negedge.
REQ-015 In IDLE, SHALL treat `load_start` as the highest-priority request: go to LOAD, clear `table_loaded`, and clear the write counter to 0.
REQ-016 In IDLE, if `run_en` is high and `table_loaded` is 1 (with no `load_start`), SHALL go to RUN; otherwise stay in IDLE.
REQ-017 In LOAD, SHALL drive `ld_ready` to 1; in all other states `ld_ready` SHALL be 0.
REQ-018 On each LOAD cycle with `ld_valid` and `ld_ready` both high, SHALL register `ram_csb0`=0, `ram_addr0`=counter and `ram_din0`=`ld_data`, then increment the counter.
REQ-019 On each LOAD cycle without a handshake, SHALL register `ram_csb0`=1.
REQ-020 On acceptance of word 255, SHALL return to IDLE and set `table_loaded` to 1 on the same edge.
REQ-021 In LOAD, SHALL ignore `load_start` and `run_en`.
REQ-022 In RUN, each cycle SHALL register `ram_csb1`=0 and `ram_addr1`=phase[ACC_WIDTH-1:ACC_WIDTH-ADDR_WIDTH], then update phase to (phase+fcw) mod 2^ACC_WIDTH.
REQ-023 SHALL handle phase wrap-around silently, with no status flag.
REQ-024 SHALL assert `sample_valid` exactly 2 clocks after each edge that registered `ram_csb1`=0, with `sample` equal to `ram_dout1` captured on that edge.
REQ-025 SHALL hold `sample` when `sample_valid` is 0.
REQ-026 On `run_en` low in RUN, SHALL go to IDLE, register `ram_csb1`=1, and retain phase.
REQ-027 SHALL still deliver reads already issued before leaving RUN (at most 2 pending samples).
REQ-028 In RUN, SHALL ignore `load_start`; the host SHALL deassert `run_en` first.
REQ-029 SHALL reset phase to 0 only on `rst`, so re-entering RUN continues the waveform phase-coherently.
REQ-030 SHALL never have `ram_csb0` and `ram_csb1` low together.

Reset
REQ-031 On `rst`, SHALL set state=IDLE, phase=0, counter=0, `table_loaded`=0, `sample`=0, `sample_valid`=0, the valid pipeline=0, `ram_csb0`=1, `ram_csb1`=1, `ram_addr0`/`ram_addr1`/`ram_din0`=0, `ld_ready`=0 and `busy`=0.
REQ-032 `rst` SHALL take priority over all inputs; reset mid-LOAD SHALL leave `table_loaded`=0, and a partial table SHALL never be read.

Structure
REQ-033 SHALL place the state enum and the DATA_WIDTH/ADDR_WIDTH/ACC_WIDTH defaults in shared package `nco_pkg`.
REQ-034 SHALL implement the phase accumulator plus 2-stage valid/capture pipeline as sub-module `nco_phase_acc`; the FSM and write path SHALL stay in the top module.
REQ-035 Testbench SHALL instantiate `nco_lut_ctrl` with `ram_256x16`.

Verification
REQ-036 Load: load ramp data=addr*3 with ld_valid always high -> 256 writes on consecutive cycles, `table_loaded`=1 after word 255, mem[k]=3k.
REQ-037 Backpressure: toggle ld_valid 1,0,0,1,... -> writes only on handshake cycles, no skipped or duplicated addresses.
REQ-038 Run: fcw=0x010000 -> ram_addr1 = 0,1,2,...; first sample_valid 2 clocks after the first csb1=0 edge, sample = 0,3,6,...,765, then wraps to 0.
REQ-039 Wrap: fcw=0x800000 -> samples alternate 0,384; fcw=0xFF0000 -> addresses 0,255,254,...
REQ-040 Reset mid-LOAD after 100 words, then run_en=1 -> stays IDLE, ram_csb1 stays 1, no sample_valid.
REQ-041 Stop/restart: run_en low for 5 cycles, then high -> 2 trailing samples then none; resumed addresses continue from the retained phase; csb0 and csb1 never low together.
